fifo_reader: RTL and testbench

//  Pop-side companion of the team's push/pop FIFO: drains the FIFO read port and

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_rd_skid.sv | 62 ++++++
 rtl/fifo_reader.sv | 89 ++++++++
 tb/tb_fifo_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO pop-side reader: skid-buffer occupancy encoding and depth.
package fifo_rd_pkg;

    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_t;

    // Occupancy as a word count, for credit arithmetic.
    function automatic logic [1:0] occ_count(input occ_t occ);
        return occ;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer (head + skid) holding words captured from the FIFO read port
// until the downstream consumer accepts them.
//
//   state | meaning
//   OCC0  | empty, out_valid low
//   OCC1  | head holds a word
//   OCC2  | head and skid both hold words
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  acc,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] skid_data;

    assign head_valid = (occ != OCC0);

    always_ff @(posedge clk) begin
        if (reset) begin
            occ       <= OCC0;
            head_data <= '0;
            skid_data <= '0;
        end else begin
            case (occ)
                OCC0: begin
                    if (cap) begin
                        head_data <= cap_data;
                        occ       <= OCC1;
                    end
                end
                OCC1: begin
                    if (cap && acc) begin
                        head_data <= cap_data;
                    end else if (cap) begin
                        skid_data <= cap_data;
                        occ       <= OCC2;
                    end else if (acc) begin
                        occ <= OCC0;
                    end
                end
                OCC2: begin
                    // Pop credit keeps a capture from arriving while both entries are full.
                    if (acc) begin
                        head_data <= skid_data;
                        occ       <= OCC1;
                    end
                end
                default: occ <= OCC0;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO read port onto a valid/ready stream with credit-based pops.
// Optional burst marking on out_last is enabled by defining FIFO_RD_LAST_EN.
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam logic [2:0] DEPTH = 3'(SKID_DEPTH);

    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("fifo_reader: BURST_LEN must be >= 1");
    end

    logic       inflight;
    logic       acc;
    occ_t       occ;
    logic [2:0] used;
    logic [2:0] limit;

    assign acc   = out_valid && out_ready;
    assign used  = {1'b0, occ_count(occ)} + {2'b00, inflight};
    // A word leaving this cycle frees an entry in time for a pop issued now.
    assign limit = DEPTH + {2'b00, acc};

    assign fifo_pop = !reset && !fifo_empty && (used < limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_pop;
            if (acc) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .cap       (inflight),
        .cap_data  (fifo_data),
        .acc       (acc),
        .head_data (out_data),
        .head_valid(out_valid),
        .occ       (occ)
    );

`ifdef FIFO_RD_LAST_EN
    localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

    logic [BURST_W-1:0] burst_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (acc) begin
            if (burst_cnt == BURST_LAST) begin
                burst_cnt <= '0;
            end else begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end

    assign out_last = out_valid && (burst_cnt == BURST_LAST);
`else
    assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: per-cycle vector table for the basic stream,
// then hand-written sequences for back-pressure, reset, bursts and count wrap.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] fifo_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] rd_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_reader #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .fifo_data (fifo_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .rd_count  (rd_count)
    );

    // Behavioural FIFO: data appears the cycle after a pop.
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_pop) begin
            fifo_data <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream monitor with a reference model of order, count and burst position.
    logic [DW-1:0] exp_q[$];
    int            acc_cyc[$];
    int            cyc = 0;
    logic [CW-1:0] mdl_cnt = '0;
    int            mdl_burst = 0;
    int            pop_cnt = 0;
    int            last_cnt = 0;
    logic          exp_last;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            mdl_cnt   = '0;
            mdl_burst = 0;
        end else begin
            chk("pop_while_empty", 32'(fifo_pop && fifo_empty), 0);
            if (fifo_pop) pop_cnt++;
            if (out_valid && out_ready) begin
`ifdef FIFO_RD_LAST_EN
                exp_last = (mdl_burst == BL - 1);
`else
                exp_last = 1'b0;
`endif
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    chk("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                chk("rd_count_at_acc", 32'(rd_count), 32'(mdl_cnt));
                chk("out_last", 32'(out_last), 32'(exp_last));
                if (out_last) last_cnt++;
                acc_cyc.push_back(cyc);
                mdl_cnt   = mdl_cnt + 1'b1;
                mdl_burst = (mdl_burst == BL - 1) ? 0 : mdl_burst + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr % 256] = v;
        wr_ptr++;
        exp_q.push_back(v);
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        flush();
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget, input bit toggle);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (toggle) out_ready = ~out_ready;
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 0);
    endtask

    typedef struct {
        logic          pop;
        logic          valid;
        logic          chk_data;
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tv [6];

    initial begin
        // Basic stream, A/B/C preloaded, out_ready held high.
        tv[0] = '{pop: 1'b1, valid: 1'b0, chk_data: 1'b0, data: 8'h00, cnt: 4'd0};
        tv[1] = '{pop: 1'b1, valid: 1'b0, chk_data: 1'b0, data: 8'h00, cnt: 4'd0};
        tv[2] = '{pop: 1'b1, valid: 1'b1, chk_data: 1'b1, data: 8'h0A, cnt: 4'd0};
        tv[3] = '{pop: 1'b0, valid: 1'b1, chk_data: 1'b1, data: 8'h0B, cnt: 4'd1};
        tv[4] = '{pop: 1'b0, valid: 1'b1, chk_data: 1'b1, data: 8'h0C, cnt: 4'd2};
        tv[5] = '{pop: 1'b0, valid: 1'b0, chk_data: 1'b0, data: 8'h00, cnt: 4'd3};

        step();
        step();
        flush();
        push(8'h0A);
        push(8'h0B);
        push(8'h0C);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_fifo_pop", 32'(fifo_pop), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t1_pop[%0d]", i), 32'(fifo_pop), 32'(tv[i].pop));
            chk($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(tv[i].valid));
            if (tv[i].chk_data) chk($sformatf("t1_data[%0d]", i), 32'(out_data), 32'(tv[i].data));
            chk($sformatf("t1_cnt[%0d]", i), 32'(rd_count), 32'(tv[i].cnt));
            step();
        end

        // Back-pressure: only two pops may be outstanding against the skid buffer.
        out_ready = 1'b0;
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        repeat (8) step();
        @(negedge clk);
        chk("t2_pop_count", 32'(pop_cnt), 2);
        chk("t2_hold_valid", 32'(out_valid), 1);
        chk("t2_hold_data", 32'(out_data), 32'h10);
        chk("t2_pop_stalled", 32'(fifo_pop), 0);
        step();
        acc_cyc.delete();
        out_ready = 1'b1;
        drain("t2_drain", 40, 1'b0);
        chk("t2_acc_count", 32'(acc_cyc.size()), 8);
        if (acc_cyc.size() == 8) chk("t2_no_gap", 32'(acc_cyc[7] - acc_cyc[0]), 7);

        // Toggling ready: order, loss and duplication are covered by the monitor.
        out_ready = 1'b0;
        acc_cyc.delete();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        drain("t3_drain", 100, 1'b1);
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("t3_acc_count", 32'(acc_cyc.size()), 16);
        chk("t3_idle_valid", 32'(out_valid), 0);
        step();

        // Reset while the buffer is full and a pop goes out.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        repeat (5) step();
        @(negedge clk);
        chk("t4_full_valid", 32'(out_valid), 1);
        chk("t4_full_nopop", 32'(fifo_pop), 0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_pop_on_acc", 32'(fifo_pop), 1);
        step();
        out_ready = 1'b0;
        do_reset(1);
        @(negedge clk);
        chk("t4_post_valid", 32'(out_valid), 0);
        chk("t4_post_count", 32'(rd_count), 0);
        chk("t4_post_pop", 32'(fifo_pop), 0);
        step();
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        out_ready = 1'b1;
        drain("t4_refill", 30, 1'b0);
        @(negedge clk);
        chk("t4_refill_count", 32'(rd_count), 4);
        step();

        // Burst marking over nine words.
        do_reset(2);
        last_cnt = 0;
        for (int i = 0; i < 9; i++) push(8'h50 + 8'(i));
        drain("t5_drain", 40, 1'b0);
`ifdef FIFO_RD_LAST_EN
        chk("t5_last_count", 32'(last_cnt), 2);
`else
        chk("t5_last_count", 32'(last_cnt), 0);
`endif
        step();

        // rd_count wraps on the sixteenth accept.
        do_reset(2);
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        drain("t6_drain", 60, 1'b0);
        @(negedge clk);
        chk("t6_wrap", 32'(rd_count), 0);
        chk("t6_model_wrap", 32'(mdl_cnt), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
